wb_spi_host_bridge: RTL

SPI target that lets an external host act as a Wishbone initiator on the on-chip bus. The host can read and write any mapped peripheral (SPI_RAM, SPI_ROM, UART, GPIO, BRAM, SPI) for debug and boot loading. It sits beside the CPU as a second bus master and has no arbitration of its own; the top level gates it against the CPU. Frames are byte-oriented: a command byte, a 32-bit address, then auto-incrementing 32-bit data words.

---
 rtl/wb_spi_host_bridge.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_spi_host_bridge.sv
// rtl/wb_spi_host_bridge.sv - SPI target that drives Wishbone read/write cycles for a host
module wb_spi_host_bridge #(
  parameter int TIMEOUT  = 255,
  parameter int RD_DUMMY = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        err_o
);

  localparam logic [5:0] DUMMY_LAST = 6'(RD_DUMMY);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDUMMY, RDATA, SKIP} state_t;
  state_t state, state_n;

  logic [2:0]  sclk_s, cs_s;
  logic [1:0]  mosi_s;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;
  logic [5:0]  bit_cnt;
  logic [31:0] shift_in, shift_nx, tx_q, addr_q, rd_data, load_word;
  logic        cmd_rd, rd_valid, rd_pend, stale, last_bit, frame_start;
  logic        addr_done, rd_launch, wr_word, rd_load;
  logic [7:0]  to_cnt;

  assign sclk_rise   = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall   = ~sclk_s[1] & sclk_s[2];
  assign cs_rise     = cs_s[1] & ~cs_s[2];
  assign cs_fall     = ~cs_s[1] & cs_s[2];
  assign mosi_bit    = mosi_s[1];
  assign shift_nx    = {shift_in[30:0], mosi_bit};
  assign last_bit    = (bit_cnt == 6'd31);
  assign frame_start = (state == IDLE) && cs_fall;
  assign load_word   = rd_valid ? rd_data : 32'h0;
  assign spi_miso_o  = (state == RDATA) ? tx_q[31] : 1'b0;
  assign wb_stb_o    = wb_cyc_o;
  assign wb_sel_o    = wb_cyc_o ? 4'b1111 : 4'b0000;

  // Two-stage synchronisers plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= 3'b000;
      cs_s   <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_sclk_i};
      cs_s   <= {cs_s[1:0], spi_cs_n_i};
      mosi_s <= {mosi_s[0], spi_mosi_i};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode and the per-cycle frame events that drive the bus engine
  always_comb begin
    state_n   = state;
    addr_done = 1'b0;
    rd_launch = 1'b0;
    wr_word   = 1'b0;
    rd_load   = 1'b0;
    if (cs_rise) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:   if (cs_fall) state_n = CMD;
        CMD:    if (sclk_rise && bit_cnt == 6'd7)
                  state_n = (shift_nx[7:0] == 8'h02 || shift_nx[7:0] == 8'h03) ? ADDR : SKIP;
        ADDR:   if (sclk_rise && last_bit) begin
                  addr_done = 1'b1;
                  rd_launch = cmd_rd;
                  state_n   = cmd_rd ? RDUMMY : WDATA;
                end
        WDATA:  wr_word = sclk_rise && last_bit;
        RDUMMY: if (sclk_fall && bit_cnt == DUMMY_LAST) begin
                  rd_load = 1'b1;
                  state_n = RDATA;
                end
        RDATA:  rd_load = sclk_fall && last_bit;
        default: ;
      endcase
    end
  end

  // SPI side: bit counting, receive shifting and transmit shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 6'd0;
      shift_in <= 32'h0;
      cmd_rd   <= 1'b0;
      tx_q     <= 32'h0;
    end else if (cs_rise) begin
      bit_cnt <= 6'd0;
    end else begin
      case (state)
        IDLE: if (cs_fall) bit_cnt <= 6'd0;
        CMD, ADDR, WDATA: if (sclk_rise) begin
          shift_in <= shift_nx;
          if (state == CMD && bit_cnt == 6'd7) begin
            bit_cnt <= 6'd0;
            cmd_rd  <= (shift_nx[7:0] == 8'h03);
          end else if (last_bit) begin
            bit_cnt <= 6'd0;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        RDUMMY, RDATA: if (rd_load) begin
          bit_cnt <= 6'd0;
          tx_q    <= load_word;
        end else if (state == RDUMMY && sclk_rise) begin
          bit_cnt <= bit_cnt + 6'd1;
        end else if (state == RDATA && sclk_fall) begin
          bit_cnt <= bit_cnt + 6'd1;
          tx_q    <= {tx_q[30:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

  // Wishbone engine: one cycle at a time; a cycle orphaned by CS rising runs to completion but its result is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_cyc_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= 32'h0;
      wb_dat_o <= 32'h0;
      err_o    <= 1'b0;
      addr_q   <= 32'h0;
      rd_data  <= 32'h0;
      rd_valid <= 1'b0;
      rd_pend  <= 1'b0;
      stale    <= 1'b0;
      to_cnt   <= 8'd0;
    end else begin
      if (frame_start) begin
        err_o    <= 1'b0;
        rd_valid <= 1'b0;
      end
      if (cs_rise) begin
        rd_pend <= 1'b0;
        if (wb_cyc_o) stale <= 1'b1;
      end
      if (addr_done) addr_q <= shift_nx;
      if (rd_load) begin
        rd_valid <= 1'b0;
        if (!rd_valid) err_o <= 1'b1;
      end
      if (wb_cyc_o) begin
        if (wb_ack_i || to_cnt == TO_LAST) begin
          wb_cyc_o <= 1'b0;
          wb_we_o  <= 1'b0;
          stale    <= 1'b0;
          if (!stale) begin
            addr_q <= addr_q + 32'd4;
            if (!wb_we_o) begin
              rd_data  <= wb_ack_i ? wb_dat_i : 32'h0;
              rd_valid <= 1'b1;
            end
            if (!wb_ack_i) err_o <= 1'b1;
          end
        end else begin
          to_cnt <= to_cnt + 8'd1;
        end
        if (rd_launch) rd_pend <= 1'b1;
        if (wr_word) err_o <= 1'b1;
      end else if (rd_launch) begin
        wb_cyc_o <= 1'b1;
        wb_we_o  <= 1'b0;
        wb_adr_o <= shift_nx;
        to_cnt   <= 8'd0;
      end else if (rd_pend || (rd_load && rd_valid)) begin
        wb_cyc_o <= 1'b1;
        wb_we_o  <= 1'b0;
        wb_adr_o <= addr_q;
        to_cnt   <= 8'd0;
        rd_pend  <= 1'b0;
      end else if (wr_word) begin
        wb_cyc_o <= 1'b1;
        wb_we_o  <= 1'b1;
        wb_adr_o <= addr_q;
        wb_dat_o <= shift_nx;
        to_cnt   <= 8'd0;
      end
    end
  end

endmodule
